// File: rtl/hazard_ctrl_pkg.sv
// Shared configuration and types for the hazard/bypass unit.
// Default datapath widths and the stall-cause encoding used for perf and debug.
package hazard_ctrl_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;

  typedef enum logic [1:0] {
    HZD_NONE = 2'd0,
    HZD_LD   = 2'd1,
    HZD_SB   = 2'd2,
    HZD_FULL = 2'd3
  } hzd_cause_t;

endpackage

// File: rtl/hazard_ctrl_regfile.sv
// Architectural 2R1W register file with x0 hard-wired to zero and synchronous reset.
// s_a0zero is a simulation convenience flag that is high while x10 holds zero.
module hzd_regfile
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = CPU_WIDTH,
  parameter int ADDRW = REG_ADDRW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wen,
  input  logic [ADDRW-1:0] i_waddr,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [ADDRW-1:0] i_raddr1,
  input  logic [ADDRW-1:0] i_raddr2,
  output logic [XLEN-1:0]  o_rdata1,
  output logic [XLEN-1:0]  o_rdata2,
  output logic             s_a0zero
);

  localparam int NREG = 2 ** ADDRW;

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (i_wen && i_waddr != '0) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : regs[i_raddr2];
  assign s_a0zero = (regs[10] == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Operand bypass, multi-cycle scoreboard and stall generation between ID and ID/EX.
// Define HAZARD_PERF_EN to add saturating stall-cause counters (o_cnt_ld/o_cnt_sb/o_cnt_full).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN   = CPU_WIDTH,
  parameter int ADDRW  = REG_ADDRW,
  parameter int NSRC   = 2,
  parameter int MC_MAX = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_vld,
  input  logic [ADDRW-1:0]      i_rs1id,
  input  logic [ADDRW-1:0]      i_rs2id,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic                  i_id_rdwen,
  input  logic [ADDRW-1:0]      i_id_rdid,
  input  logic                  i_id_mc,
  input  logic [NSRC-1:0]       i_fwd_vld,
  input  logic [NSRC*ADDRW-1:0] i_fwd_rdid,
  input  logic [NSRC-1:0]       i_fwd_rdy,
  input  logic [NSRC*XLEN-1:0]  i_fwd_data,
  input  logic                  i_wbu_rdwen,
  input  logic [ADDRW-1:0]      i_wbu_rdid,
  input  logic [XLEN-1:0]       i_wbu_rd,
  input  logic                  i_mc_done,
  input  logic [ADDRW-1:0]      i_mc_rdid,
  output logic [XLEN-1:0]       o_rs1,
  output logic [XLEN-1:0]       o_rs2,
  output logic                  o_pc_wen,
  output logic                  o_ifid_wen,
  output logic                  o_idex_bubble,
  output logic                  o_mc_full,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           o_cnt_ld,
  output logic [31:0]           o_cnt_sb,
  output logic [31:0]           o_cnt_full,
`endif
  output logic                  s_a0zero
);

  localparam int NREG = 2 ** ADDRW;
  localparam int CW   = $clog2(MC_MAX + 1);
  localparam logic [CW-1:0] MC_MAX_C = CW'(MC_MAX);

  logic [ADDRW-1:0] fwd_rdid [NSRC];
  logic [XLEN-1:0]  fwd_data [NSRC];
  logic [ADDRW-1:0] src_id   [2];
  logic             src_used [2];
  logic [XLEN-1:0]  rf_data  [2];
  logic [XLEN-1:0]  src_val  [2];
  logic             src_ld   [2];
  logic             src_hit  [2];
  logic             src_sb   [2];

  logic [NREG-1:0]  sb, sb_nxt;
  logic [CW-1:0]    mc_cnt;
  logic             ld_hzd, sb_hzd, waw_hzd, cap_hzd;
  logic             stall, issue;
  hzd_cause_t       hzd_cause;

  for (genvar k = 0; k < NSRC; k++) begin : g_fwd
    assign fwd_rdid[k] = i_fwd_rdid[k*ADDRW +: ADDRW];
    assign fwd_data[k] = i_fwd_data[k*XLEN +: XLEN];
  end

  assign src_id[0]   = i_rs1id;
  assign src_id[1]   = i_rs2id;
  assign src_used[0] = i_rs1_used;
  assign src_used[1] = i_rs2_used;

  hzd_regfile #(.XLEN(XLEN), .ADDRW(ADDRW)) u_regfile (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wen    (i_wbu_rdwen),
    .i_waddr  (i_wbu_rdid),
    .i_wdata  (i_wbu_rd),
    .i_raddr1 (i_rs1id),
    .i_raddr2 (i_rs2id),
    .o_rdata1 (rf_data[0]),
    .o_rdata2 (rf_data[1]),
    .s_a0zero (s_a0zero)
  );

  // The youngest matching stage owns the operand; if its data is not ready we stall
  // rather than fall through to older (stale) copies.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_val[s] = '0;
      src_ld[s]  = 1'b0;
      src_hit[s] = 1'b0;
      src_sb[s]  = 1'b0;
      if (src_id[s] != '0) begin
        for (int k = 0; k < NSRC; k++) begin
          if (!src_hit[s] && i_fwd_vld[k] && fwd_rdid[k] == src_id[s]) begin
            src_hit[s] = 1'b1;
            if (i_fwd_rdy[k]) src_val[s] = fwd_data[k];
            else              src_ld[s]  = 1'b1;
          end
        end
        if (!src_hit[s]) begin
          src_val[s] = (i_wbu_rdwen && i_wbu_rdid == src_id[s]) ? i_wbu_rd : rf_data[s];
        end
        src_sb[s] = src_used[s] && sb[src_id[s]] && !(i_mc_done && i_mc_rdid == src_id[s]);
      end
    end
  end

  assign o_rs1 = src_val[0];
  assign o_rs2 = src_val[1];

  assign ld_hzd  = (src_ld[0] && i_rs1_used) || (src_ld[1] && i_rs2_used);
  assign sb_hzd  = src_sb[0] || src_sb[1];
  assign waw_hzd = i_id_rdwen && i_id_rdid != '0 && sb[i_id_rdid]
                   && !(i_mc_done && i_mc_rdid == i_id_rdid);
  assign cap_hzd = i_id_mc && mc_cnt == MC_MAX_C && !i_mc_done;

  always_comb begin
    hzd_cause = HZD_NONE;
    if (ld_hzd)                  hzd_cause = HZD_LD;
    else if (sb_hzd || waw_hzd)  hzd_cause = HZD_SB;
    else if (cap_hzd)            hzd_cause = HZD_FULL;
  end

  assign stall         = i_id_vld && hzd_cause != HZD_NONE;
  assign issue         = i_id_vld && !stall && i_id_mc;
  assign o_pc_wen      = ~stall;
  assign o_ifid_wen    = ~stall;
  assign o_idex_bubble = stall;
  assign o_mc_full     = (mc_cnt == MC_MAX_C);

  // Clear first, then set, so an issue reusing the completing id keeps its bit.
  always_comb begin
    sb_nxt = sb;
    if (i_mc_done) sb_nxt[i_mc_rdid] = 1'b0;
    if (issue && i_id_rdid != '0) sb_nxt[i_id_rdid] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sb     <= '0;
      mc_cnt <= '0;
    end else begin
      sb <= sb_nxt;
      if (issue && !i_mc_done && mc_cnt != MC_MAX_C) begin
        mc_cnt <= mc_cnt + 1'b1;
      end else if (!issue && i_mc_done && mc_cnt != '0) begin
        mc_cnt <= mc_cnt - 1'b1;
      end
    end
  end

  a_done_nonzero: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_mc_done && mc_cnt == '0));

  a_done_wb: assert property (@(posedge i_clk) disable iff (i_rst)
    i_mc_done |-> (i_wbu_rdwen && i_wbu_rdid == i_mc_rdid));

`ifdef HAZARD_PERF_EN
  // Every active cause counts independently, so one cycle can bump several counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_ld   <= '0;
      o_cnt_sb   <= '0;
      o_cnt_full <= '0;
    end else begin
      if (i_id_vld && ld_hzd && o_cnt_ld != '1)                o_cnt_ld   <= o_cnt_ld + 1'b1;
      if (i_id_vld && (sb_hzd || waw_hzd) && o_cnt_sb != '1)   o_cnt_sb   <= o_cnt_sb + 1'b1;
      if (i_id_vld && cap_hzd && o_cnt_full != '1)             o_cnt_full <= o_cnt_full + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: bypass priority, load-use, x0,
// scoreboard/WAW, capacity and mid-operation reset.
module tb_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int ADDRW = 5;
  localparam int NSRC  = 2;

  logic                  clk;
  logic                  i_rst;
  logic                  i_id_vld;
  logic [ADDRW-1:0]      i_rs1id, i_rs2id;
  logic                  i_rs1_used, i_rs2_used;
  logic                  i_id_rdwen;
  logic [ADDRW-1:0]      i_id_rdid;
  logic                  i_id_mc;
  logic [NSRC-1:0]       i_fwd_vld;
  logic [NSRC*ADDRW-1:0] i_fwd_rdid;
  logic [NSRC-1:0]       i_fwd_rdy;
  logic [NSRC*XLEN-1:0]  i_fwd_data;
  logic                  i_wbu_rdwen;
  logic [ADDRW-1:0]      i_wbu_rdid;
  logic [XLEN-1:0]       i_wbu_rd;
  logic                  i_mc_done;
  logic [ADDRW-1:0]      i_mc_rdid;
  logic [XLEN-1:0]       o_rs1, o_rs2;
  logic                  o_pc_wen, o_ifid_wen, o_idex_bubble, o_mc_full, s_a0zero;
`ifdef HAZARD_PERF_EN
  logic [31:0]           o_cnt_ld, o_cnt_sb, o_cnt_full;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.XLEN(XLEN), .ADDRW(ADDRW), .NSRC(NSRC), .MC_MAX(2)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_id_vld      (i_id_vld),
    .i_rs1id       (i_rs1id),
    .i_rs2id       (i_rs2id),
    .i_rs1_used    (i_rs1_used),
    .i_rs2_used    (i_rs2_used),
    .i_id_rdwen    (i_id_rdwen),
    .i_id_rdid     (i_id_rdid),
    .i_id_mc       (i_id_mc),
    .i_fwd_vld     (i_fwd_vld),
    .i_fwd_rdid    (i_fwd_rdid),
    .i_fwd_rdy     (i_fwd_rdy),
    .i_fwd_data    (i_fwd_data),
    .i_wbu_rdwen   (i_wbu_rdwen),
    .i_wbu_rdid    (i_wbu_rdid),
    .i_wbu_rd      (i_wbu_rd),
    .i_mc_done     (i_mc_done),
    .i_mc_rdid     (i_mc_rdid),
    .o_rs1         (o_rs1),
    .o_rs2         (o_rs2),
    .o_pc_wen      (o_pc_wen),
    .o_ifid_wen    (o_ifid_wen),
    .o_idex_bubble (o_idex_bubble),
    .o_mc_full     (o_mc_full),
`ifdef HAZARD_PERF_EN
    .o_cnt_ld      (o_cnt_ld),
    .o_cnt_sb      (o_cnt_sb),
    .o_cnt_full    (o_cnt_full),
`endif
    .s_a0zero      (s_a0zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change 1ns after the rising edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_id_vld = 0; i_rs1id = 0; i_rs2id = 0; i_rs1_used = 0; i_rs2_used = 0;
    i_id_rdwen = 0; i_id_rdid = 0; i_id_mc = 0;
    i_fwd_vld = '0; i_fwd_rdid = '0; i_fwd_rdy = '0; i_fwd_data = '0;
    i_wbu_rdwen = 0; i_wbu_rdid = 0; i_wbu_rd = '0; i_mc_done = 0; i_mc_rdid = 0;
  endtask

  task automatic set_fwd(input int k, input logic vld, input logic [ADDRW-1:0] rdid,
                         input logic rdy, input logic [XLEN-1:0] data);
    i_fwd_vld[k] = vld;
    i_fwd_rdid[k*ADDRW +: ADDRW] = rdid;
    i_fwd_rdy[k] = rdy;
    i_fwd_data[k*XLEN +: XLEN] = data;
  endtask

  task automatic set_wb(input logic en, input logic [ADDRW-1:0] id, input logic [XLEN-1:0] d);
    i_wbu_rdwen = en; i_wbu_rdid = id; i_wbu_rd = d;
  endtask

  task automatic test_reset();
    idle();
    i_rst = 1;
    tick();
    i_rst = 0;
    i_rs1id = 3; i_rs2id = 10;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bubble got=%b exp=0", o_idex_bubble); end
    n_tests++; if (o_pc_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_pc_wen got=%b exp=1", o_pc_wen); end
    n_tests++; if (o_ifid_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ifid_wen got=%b exp=1", o_ifid_wen); end
    n_tests++; if (o_mc_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mc_full got=%b exp=0", o_mc_full); end
    n_tests++; if (o_rs1 !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rs1 got=%h exp=0", o_rs1); end
    n_tests++; if (o_rs2 !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rs2 got=%h exp=0", o_rs2); end
    n_tests++; if (s_a0zero !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_a0zero got=%b exp=1", s_a0zero); end
  endtask

  task automatic test_priority();
    idle();
    i_id_vld = 1; i_rs1id = 5; i_rs1_used = 1;
    set_fwd(0, 1, 5, 1, 64'hAA);
    set_fwd(1, 1, 5, 1, 64'hBB);
    set_wb(1, 5, 64'hCC);
    #1;
    n_tests++; if (o_rs1 !== 64'hAA) begin n_fail++; $display("[TB] FAIL prio_fwd0 got=%h exp=aa", o_rs1); end
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_nostall got=%b exp=0", o_idex_bubble); end
    set_fwd(1, 1, 5, 0, 64'hBB);
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_older_notrdy got=%b exp=0", o_idex_bubble); end
    set_fwd(0, 1, 5, 0, 64'hAA);
    set_fwd(1, 1, 5, 1, 64'hBB);
    #1;
    n_tests++; if (o_idex_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_young_notrdy got=%b exp=1", o_idex_bubble); end
    set_fwd(0, 0, 5, 1, 64'hAA);
    #1;
    n_tests++; if (o_rs1 !== 64'hBB) begin n_fail++; $display("[TB] FAIL prio_fwd1 got=%h exp=bb", o_rs1); end
    set_fwd(1, 0, 5, 1, 64'hBB);
    #1;
    n_tests++; if (o_rs1 !== 64'hCC) begin n_fail++; $display("[TB] FAIL prio_wb got=%h exp=cc", o_rs1); end
    tick();
    set_wb(0, 0, '0);
    #1;
    n_tests++; if (o_rs1 !== 64'hCC) begin n_fail++; $display("[TB] FAIL prio_regfile got=%h exp=cc", o_rs1); end
  endtask

  task automatic test_load_use();
    idle();
    i_id_vld = 1; i_rs2id = 7; i_rs2_used = 1;
    set_fwd(0, 1, 7, 0, 64'h0);
    #1;
    n_tests++; if (o_idex_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_bubble got=%b exp=1", o_idex_bubble); end
    n_tests++; if (o_pc_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_pc_wen got=%b exp=0", o_pc_wen); end
    n_tests++; if (o_ifid_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_ifid_wen got=%b exp=0", o_ifid_wen); end
    tick();
    set_fwd(0, 1, 7, 1, 64'h1234);
    #1;
    n_tests++; if (o_rs2 !== 64'h1234) begin n_fail++; $display("[TB] FAIL lu_data got=%h exp=1234", o_rs2); end
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_release got=%b exp=0", o_idex_bubble); end
    set_fwd(0, 1, 7, 0, 64'h0);
    i_rs2_used = 0;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_unused got=%b exp=0", o_idex_bubble); end
    i_rs2_used = 1; i_id_vld = 0;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_novld got=%b exp=0", o_idex_bubble); end
  endtask

  task automatic test_x0();
    idle();
    i_id_vld = 1; i_rs1id = 0; i_rs1_used = 1;
    set_fwd(0, 1, 0, 0, 64'hDEAD);
    #1;
    n_tests++; if (o_rs1 !== 64'h0) begin n_fail++; $display("[TB] FAIL x0_fwd got=%h exp=0", o_rs1); end
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_nostall got=%b exp=0", o_idex_bubble); end
    set_fwd(0, 0, 0, 0, 64'h0);
    set_wb(1, 0, 64'hFF);
    #1;
    n_tests++; if (o_rs1 !== 64'h0) begin n_fail++; $display("[TB] FAIL x0_wb_bypass got=%h exp=0", o_rs1); end
    tick();
    set_wb(0, 0, '0);
    #1;
    n_tests++; if (o_rs1 !== 64'h0) begin n_fail++; $display("[TB] FAIL x0_regfile got=%h exp=0", o_rs1); end
  endtask

  task automatic test_scoreboard();
    int stalls;
    idle();
    i_id_vld = 1; i_id_mc = 1; i_id_rdwen = 1; i_id_rdid = 9;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_issue got=%b exp=0", o_idex_bubble); end
    tick();
    idle();
    i_id_vld = 1; i_rs1id = 9; i_rs1_used = 1;
    #1;
    n_tests++; if (o_mc_full !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_notfull got=%b exp=0", o_mc_full); end
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (o_idex_bubble === 1'b1) stalls++;
      tick();
    end
    n_tests++; if (stalls !== 20) begin n_fail++; $display("[TB] FAIL sb_stall_cycles got=%0d exp=20", stalls); end
    i_rs1_used = 0; i_id_rdwen = 1; i_id_rdid = 9;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_waw got=%b exp=1", o_idex_bubble); end
    i_id_rdwen = 0;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_unused got=%b exp=0", o_idex_bubble); end
    i_rs1_used = 1;
    i_mc_done = 1; i_mc_rdid = 9;
    set_wb(1, 9, 64'h55);
    #1;
    n_tests++; if (o_rs1 !== 64'h55) begin n_fail++; $display("[TB] FAIL sb_done_data got=%h exp=55", o_rs1); end
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_done_release got=%b exp=0", o_idex_bubble); end
    tick();
    i_mc_done = 0; i_mc_rdid = 0;
    set_wb(0, 0, '0);
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_cleared got=%b exp=0", o_idex_bubble); end
    n_tests++; if (o_rs1 !== 64'h55) begin n_fail++; $display("[TB] FAIL sb_regfile got=%h exp=55", o_rs1); end
  endtask

  task automatic test_capacity();
    idle();
    i_id_vld = 1; i_id_mc = 1; i_id_rdwen = 1; i_id_rdid = 11;
    tick();
    i_id_rdid = 12;
    tick();
    i_id_rdid = 13;
    #1;
    n_tests++; if (o_mc_full !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_full got=%b exp=1", o_mc_full); end
    n_tests++; if (o_idex_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_third_stall got=%b exp=1", o_idex_bubble); end
    tick();
    i_mc_done = 1; i_mc_rdid = 11;
    set_wb(1, 11, 64'h77);
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_done_issue got=%b exp=0", o_idex_bubble); end
    tick();
    idle();
    #1;
    n_tests++; if (o_mc_full !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_still_full got=%b exp=1", o_mc_full); end
    i_id_vld = 1; i_rs1id = 13; i_rs1_used = 1;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_sb13 got=%b exp=1", o_idex_bubble); end
    i_rs1id = 11;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_sb11_clear got=%b exp=0", o_idex_bubble); end
    n_tests++; if (o_rs1 !== 64'h77) begin n_fail++; $display("[TB] FAIL cap_rf11 got=%h exp=77", o_rs1); end
    idle();
    i_mc_done = 1; i_mc_rdid = 12; set_wb(1, 12, 64'h12);
    tick();
    i_mc_rdid = 13; set_wb(1, 13, 64'h13);
    tick();
    idle();
    #1;
    n_tests++; if (o_mc_full !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_drained got=%b exp=0", o_mc_full); end
  endtask

  task automatic test_reset_mid();
    idle();
    i_id_vld = 1; i_id_mc = 1; i_id_rdwen = 1; i_id_rdid = 3;
    set_wb(1, 4, 64'h99);
    tick();
    idle();
    i_id_vld = 1; i_rs1id = 3; i_rs1_used = 1; i_rs2id = 4; i_rs2_used = 1;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_pre_stall got=%b exp=1", o_idex_bubble); end
    n_tests++; if (o_rs2 !== 64'h99) begin n_fail++; $display("[TB] FAIL rm_pre_rs2 got=%h exp=99", o_rs2); end
    i_rst = 1;
    tick();
    i_rst = 0;
    #1;
    n_tests++; if (o_idex_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_nostall got=%b exp=0", o_idex_bubble); end
    n_tests++; if (o_mc_full !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_mc_full got=%b exp=0", o_mc_full); end
    n_tests++; if (o_rs2 !== 64'h0) begin n_fail++; $display("[TB] FAIL rm_rf_cleared got=%h exp=0", o_rs2); end
`ifdef HAZARD_PERF_EN
    n_tests++; if (o_cnt_ld !== 32'd0) begin n_fail++; $display("[TB] FAIL rm_cnt_ld got=%0d exp=0", o_cnt_ld); end
    n_tests++; if (o_cnt_sb !== 32'd0) begin n_fail++; $display("[TB] FAIL rm_cnt_sb got=%0d exp=0", o_cnt_sb); end
    n_tests++; if (o_cnt_full !== 32'd0) begin n_fail++; $display("[TB] FAIL rm_cnt_full got=%0d exp=0", o_cnt_full); end
`endif
  endtask

  initial begin
    i_rst = 1;
    idle();
    repeat (2) tick();
    test_reset();
    test_priority();
    test_load_use();
    test_x0();
    test_scoreboard();
    test_capacity();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
